// File: rtl/dsp48a1_preadder_stage_if.sv
// rtl/dsp48a1_preadder_stage_if.sv - operand/result bundle for the DSP48A1 pre-adder stage
interface dsp48a1_preadder_stage_if #(
    parameter int WIDTH = 18
);
    logic             in_valid;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] B;
    logic             opmode_sub;
    logic             opmode_pre;
    logic [WIDTH-1:0] out;
    logic             carry_out;
    logic             out_valid;

    modport master (
        output in_valid, D, B, opmode_sub, opmode_pre,
        input  out, carry_out, out_valid
    );

    modport slave (
        input  in_valid, D, B, opmode_sub, opmode_pre,
        output out, carry_out, out_valid
    );
endinterface

// File: rtl/dsp48a1_preadder_stage.sv
// rtl/dsp48a1_preadder_stage.sv - DSP48A1 pre-adder/subtracter with optional input and B1 registers
module dsp48a1_preadder_stage #(
    parameter int WIDTH = 18,
    parameter bit REG1  = 1'b1,
    parameter bit REG2  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    dsp48a1_preadder_stage_if.slave   bus
);
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] b1;
    logic             sub1;
    logic             pre1;
    logic             valid1;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] mux_res;
    logic             mux_flag;

    // Keeps the purely combinational configuration free of dangling-input noise.
    logic unused_ok;
    assign unused_ok = ^{clk, rst, ce};

    generate
        if (REG1) begin : g_reg1
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    d1     <= '0;
                    b1     <= '0;
                    sub1   <= 1'b0;
                    pre1   <= 1'b0;
                    valid1 <= 1'b0;
                end else if (ce) begin
                    d1     <= bus.D;
                    b1     <= bus.B;
                    sub1   <= bus.opmode_sub;
                    pre1   <= bus.opmode_pre;
                    valid1 <= bus.in_valid;
                end
            end
        end else begin : g_noreg1
            assign d1     = bus.D;
            assign b1     = bus.B;
            assign sub1   = bus.opmode_sub;
            assign pre1   = bus.opmode_pre;
            assign valid1 = bus.in_valid;
        end
    endgenerate

    // Zero-extended subtraction leaves the unsigned borrow in the top bit.
    assign sum  = {1'b0, d1} + {1'b0, b1};
    assign diff = {1'b0, d1} - {1'b0, b1};

    always_comb begin
        mux_res  = b1;
        mux_flag = 1'b0;
        if (pre1) begin
            if (sub1) begin
                mux_res  = diff[WIDTH-1:0];
                mux_flag = diff[WIDTH];
            end else begin
                mux_res  = sum[WIDTH-1:0];
                mux_flag = sum[WIDTH];
            end
        end
    end

    generate
        if (REG2) begin : g_reg2
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    bus.out       <= '0;
                    bus.carry_out <= 1'b0;
                    bus.out_valid <= 1'b0;
                end else if (ce) begin
                    bus.out       <= mux_res;
                    bus.carry_out <= mux_flag;
                    bus.out_valid <= valid1;
                end
            end
        end else begin : g_noreg2
            assign bus.out       = mux_res;
            assign bus.carry_out = mux_flag;
            assign bus.out_valid = valid1;
        end
    endgenerate
endmodule

// File: tb/tb_dsp48a1_preadder_stage.sv
// tb/tb_dsp48a1_preadder_stage.sv - self-checking bench across all four register configurations
module tb_dsp48a1_preadder_stage;
    localparam int W = 18;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ce  = 1'b1;

    logic         v   = 1'b0;
    logic [W-1:0] d   = '0;
    logic [W-1:0] b   = '0;
    logic         sub = 1'b0;
    logic         pre = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    // Model history: operand tuples captured at the last two enabled edges.
    logic [2*W+2:0] h1;
    logic [2*W+2:0] h2;

    always #5 clk = ~clk;

    dsp48a1_preadder_stage_if #(.WIDTH(W)) if00 ();
    dsp48a1_preadder_stage_if #(.WIDTH(W)) if10 ();
    dsp48a1_preadder_stage_if #(.WIDTH(W)) if01 ();
    dsp48a1_preadder_stage_if #(.WIDTH(W)) if11 ();

    assign if00.in_valid = v;   assign if00.D = d; assign if00.B = b;
    assign if00.opmode_sub = sub; assign if00.opmode_pre = pre;
    assign if10.in_valid = v;   assign if10.D = d; assign if10.B = b;
    assign if10.opmode_sub = sub; assign if10.opmode_pre = pre;
    assign if01.in_valid = v;   assign if01.D = d; assign if01.B = b;
    assign if01.opmode_sub = sub; assign if01.opmode_pre = pre;
    assign if11.in_valid = v;   assign if11.D = d; assign if11.B = b;
    assign if11.opmode_sub = sub; assign if11.opmode_pre = pre;

    dsp48a1_preadder_stage #(.WIDTH(W), .REG1(1'b0), .REG2(1'b0)) u00 (.clk(clk), .rst(rst), .ce(ce), .bus(if00.slave));
    dsp48a1_preadder_stage #(.WIDTH(W), .REG1(1'b1), .REG2(1'b0)) u10 (.clk(clk), .rst(rst), .ce(ce), .bus(if10.slave));
    dsp48a1_preadder_stage #(.WIDTH(W), .REG1(1'b0), .REG2(1'b1)) u01 (.clk(clk), .rst(rst), .ce(ce), .bus(if01.slave));
    dsp48a1_preadder_stage #(.WIDTH(W), .REG1(1'b1), .REG2(1'b1)) u11 (.clk(clk), .rst(rst), .ce(ce), .bus(if11.slave));

    logic [W+1:0] obs [4];
    assign obs[0] = {if00.out_valid, if00.carry_out, if00.out};
    assign obs[1] = {if10.out_valid, if10.carry_out, if10.out};
    assign obs[2] = {if01.out_valid, if01.carry_out, if01.out};
    assign obs[3] = {if11.out_valid, if11.carry_out, if11.out};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour: returns {valid, flag, result} for one operand tuple.
    function automatic logic [W+1:0] ref_op(input logic [2*W+2:0] t);
        logic         tv, ts, tp;
        logic [W-1:0] td, tb;
        int unsigned  dd, bb, res;
        logic         flag;
        {tv, ts, tp, td, tb} = t;
        dd = td;
        bb = tb;
        if (!tp) begin
            res  = bb;
            flag = 1'b0;
        end else if (ts) begin
            res  = (dd + (1 << W) - bb) % (1 << W);
            flag = dd < bb;
        end else begin
            res  = (dd + bb) % (1 << W);
            flag = (dd + bb) >= (1 << W);
        end
        return {tv, flag, res[W-1:0]};
    endfunction

    function automatic logic [2*W+2:0] cur_tuple();
        return {v, sub, pre, d, b};
    endfunction

    task automatic check_all(input string tag);
        logic [W+1:0] e [4];
        e[0] = ref_op(cur_tuple());
        e[1] = ref_op(h1);
        e[2] = ref_op(h1);
        e[3] = ref_op(h2);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s.cfg%0d.out", tag, i),   32'(obs[i][W-1:0]), 32'(e[i][W-1:0]));
            check($sformatf("%s.cfg%0d.carry", tag, i), 32'(obs[i][W]),     32'(e[i][W]));
            check($sformatf("%s.cfg%0d.valid", tag, i), 32'(obs[i][W+1]),   32'(e[i][W+1]));
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (rst && ce) begin
            h2 = h1;
            h1 = cur_tuple();
        end
        #1;
        check_all(tag);
    endtask

    task automatic set_op(input logic nv, input int nd, input int nb, input logic ns, input logic np);
        v   = nv;
        d   = W'(nd);
        b   = W'(nb);
        sub = ns;
        pre = np;
    endtask

    task automatic mid_reset(input string tag);
        #2 rst = 1'b0;
        h1 = '0;
        h2 = '0;
        #1 check_all(tag);
        tick({tag, ".hold"});
        #2 rst = 1'b1;
    endtask

    initial begin
        h1 = '0;
        h2 = '0;

        // Reset state, then async reset mid-cycle wipes in-flight work
        #1 check_all("por");
        tick("por_edge");
        #2 rst = 1'b1;
        set_op(1'b1, 'h12345, 'h00010, 1'b0, 1'b1);
        tick("rst_fill1");
        tick("rst_fill2");
        #2 rst = 1'b0;
        #1;
        check("rst_async.out",   32'(if11.out),       32'h0);
        check("rst_async.carry", 32'(if11.carry_out), 32'h0);
        check("rst_async.valid", 32'(if11.out_valid), 32'h0);
        h1 = '0;
        h2 = '0;
        check_all("rst_async");
        tick("rst_hold");
        #2 rst = 1'b1;
        set_op(1'b0, 0, 0, 1'b0, 1'b0);
        tick("rst_release");
        tick("rst_release2");

        // Add with latency per configuration
        set_op(1'b1, 100, 25, 1'b0, 1'b1);
        #1;
        check("add_l0.out",   32'(if00.out),       32'd125);
        check("add_l0.valid", 32'(if00.out_valid), 32'd1);
        tick("add_e1");
        check("add_l1a.out",   32'(if10.out),       32'd125);
        check("add_l1b.out",   32'(if01.out),       32'd125);
        check("add_l1.valid",  32'(if10.out_valid & if01.out_valid), 32'd1);
        check("add_l2_early",  32'(if11.out_valid), 32'd0);
        set_op(1'b0, 0, 0, 1'b0, 1'b0);
        tick("add_e2");
        check("add_l2.out",   32'(if11.out),       32'd125);
        check("add_l2.carry", 32'(if11.carry_out), 32'd0);
        check("add_l2.valid", 32'(if11.out_valid), 32'd1);
        check("add_l1_once",  32'(if10.out_valid), 32'd0);
        tick("add_e3");
        check("add_l2_once",  32'(if11.out_valid), 32'd0);

        // Borrow and carry wrap-around
        set_op(1'b1, 5, 7, 1'b1, 1'b1);
        #1;
        check("borrow.out",   32'(if00.out),       32'h3FFFE);
        check("borrow.carry", 32'(if00.carry_out), 32'd1);
        tick("borrow");
        set_op(1'b1, MAXV, 1, 1'b0, 1'b1);
        #1;
        check("wrap.out",   32'(if00.out),       32'h0);
        check("wrap.carry", 32'(if00.carry_out), 32'd1);
        tick("wrap");

        // Opmode travels with its own data
        set_op(1'b1, 10, 3, 1'b1, 1'b1);
        tick("align1");
        set_op(1'b1, 10, 3, 1'b0, 1'b0);
        tick("align2");
        check("align_a.out",   32'(if11.out),       32'd7);
        check("align_a.carry", 32'(if11.carry_out), 32'd0);
        set_op(1'b0, 0, 0, 1'b0, 1'b0);
        tick("align3");
        check("align_b.out",   32'(if11.out),       32'd3);
        check("align_b.carry", 32'(if11.carry_out), 32'd0);
        check("align_b.valid", 32'(if11.out_valid), 32'd1);

        // Stall with three ops in flight
        set_op(1'b1, 1, 2, 1'b0, 1'b1);
        tick("stall_op1");
        ce = 1'b0;
        set_op(1'b1, 9, 4, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) tick("stall_hold");
        ce = 1'b1;
        tick("stall_op2");
        set_op(1'b1, 300, 1000, 1'b1, 1'b1);
        tick("stall_op3");
        set_op(1'b0, 0, 0, 1'b0, 1'b0);
        tick("stall_drain1");
        tick("stall_drain2");

        // Randomized ops, stalls and occasional async resets
        for (int n = 0; n < 600; n++) begin
            int sel;
            sel = int'($urandom_range(0, 3));
            v   = 1'($urandom);
            sub = 1'($urandom);
            pre = ($urandom_range(0, 3) != 0);
            d   = (sel == 0) ? W'(MAXV) : (sel == 1) ? W'($urandom_range(0, 3)) : W'($urandom);
            b   = (sel == 2) ? W'(MAXV) : (sel == 3) ? W'($urandom_range(0, 3)) : W'($urandom);
            ce  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 59) == 0)
                mid_reset("rnd_rst");
            else
                tick("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
